// File: rtl/rans_encoder_iter.sv
// rANS encoder: iterative restoring divide, digit renormalisation, flush.
// Emits OUT_W-bit digits LSB-first; the last flush digit carries out_last.
module rans_encoder_iter #(
  parameter int STATE_W   = 16,
  parameter int OUT_W     = 4,
  parameter int PROB_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [PROB_BITS-1:0] s_freq,
  input  logic [PROB_BITS-1:0] s_cum,
  input  logic                 in_flush,
  input  logic                 in_vld,
  output logic                 in_rdy,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic                 out_last,
  output logic                 busy,
  output logic                 err
);

  localparam int DIGITS = STATE_W / OUT_W;
  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam int DIV_W  = $clog2(STATE_W + 1);
  localparam int Q_W    = STATE_W - PROB_BITS;
  localparam logic [STATE_W-1:0] L =
    STATE_W'(1) << (STATE_W - OUT_W);

  typedef enum logic [2:0] {
    IDLE, RENORM, EMIT, DIVIDE, FLUSH
  } state_t;

  state_t               state, nxt;
  logic [STATE_W-1:0]   x;
  logic [PROB_BITS-1:0] f_q, c_q;
  logic                 flush_q;
  logic [CNT_W-1:0]     dcnt;
  logic [DIV_W-1:0]     div_cnt;
  logic [PROB_BITS-1:0] rem;
  logic [STATE_W-1:0]   quo;

  logic [STATE_W-1:0]   bound;
  logic                 need_emit;
  logic [PROB_BITS:0]   trial, diff;
  logic                 ge;
  logic [PROB_BITS-1:0] rem_n;
  logic [STATE_W-1:0]   quo_n;
  logic [STATE_W-1:0]   x_new;

  assign in_rdy    = (state == IDLE);
  assign busy      = (state != IDLE);
  assign bound     = STATE_W'(f_q) << Q_W;
  assign need_emit = (x >= bound);

  // One restoring step: dividend bits enter from the top of quo,
  // quotient bits fill in from the bottom.
  assign trial = {rem, quo[STATE_W-1]};
  assign diff  = trial - {1'b0, f_q};
  assign ge    = (trial >= {1'b0, f_q});
  assign rem_n = ge ? diff[PROB_BITS-1:0] : trial[PROB_BITS-1:0];
  assign quo_n = {quo[STATE_W-2:0], ge};
  assign x_new = {quo_n[Q_W-1:0], {PROB_BITS{1'b0}}}
               + STATE_W'(c_q) + STATE_W'(rem_n);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:
        if (in_vld) begin
          if (in_flush)          nxt = FLUSH;
          else if (s_freq != '0) nxt = RENORM;
        end
      RENORM: nxt = need_emit ? EMIT : DIVIDE;
      EMIT:
        if (out_rdy) nxt = flush_q ? FLUSH : RENORM;
      DIVIDE:
        if (div_cnt == DIV_W'(1)) nxt = IDLE;
      FLUSH:  nxt = (dcnt != '0) ? EMIT : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else if (ena) state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x        <= L;
      f_q      <= '0;
      c_q      <= '0;
      flush_q  <= 1'b0;
      dcnt     <= '0;
      div_cnt  <= '0;
      rem      <= '0;
      quo      <= '0;
      out_data <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      err      <= 1'b0;
    end else if (ena) begin
      unique case (state)
        IDLE:
          if (in_vld) begin
            f_q     <= s_freq;
            c_q     <= s_cum;
            flush_q <= in_flush;
            if (in_flush)
              dcnt <= CNT_W'(DIGITS);
            else if (s_freq == '0)
              err <= 1'b1;
          end
        RENORM:
          if (need_emit) begin
            out_data <= x[OUT_W-1:0];
            out_vld  <= 1'b1;
          end else begin
            quo     <= x;
            rem     <= '0;
            div_cnt <= DIV_W'(STATE_W);
          end
        EMIT:
          if (out_rdy) begin
            x        <= x >> OUT_W;
            out_vld  <= 1'b0;
            out_last <= 1'b0;
          end
        DIVIDE: begin
          quo     <= quo_n;
          rem     <= rem_n;
          div_cnt <= div_cnt - DIV_W'(1);
          if (div_cnt == DIV_W'(1)) x <= x_new;
        end
        FLUSH:
          if (dcnt != '0) begin
            out_data <= x[OUT_W-1:0];
            out_vld  <= 1'b1;
            out_last <= (dcnt == CNT_W'(1));
            dcnt     <= dcnt - CNT_W'(1);
          end else begin
            x <= L;
          end
        default: ;
      endcase
    end
  end

endmodule
